// File: rtl/fanout_pkg.sv
// Shared constants, width helper and per-channel status record for the fanout fork buffer.
package fanout_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_LOADS = 4;
  localparam int DEF_DEPTH     = 4;

  // Widest occupancy counter needed across the legal DEPTH range (up to 32 entries).
  localparam int MAX_CW = 6;

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic              full;
    logic              empty;
    logic [MAX_CW-1:0] occupancy;
  } ch_status_t;

endpackage

// File: rtl/fanout_fifo.sv
// One load branch: circular FIFO with registered full/empty flags and an entry counter.
module fanout_fifo
  import fanout_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_ready_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output ch_status_t       status_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cw_of(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok, pop_ok;

  // Pushes into a full FIFO are dropped here as a safety net; the fork already stalls them.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_ready_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    status_o           = '0;
    status_o.full      = full_q;
    status_o.empty     = empty_q;
    status_o.occupancy = MAX_CW'(cnt_q);
  end

endmodule

// File: rtl/fanout_fork_buffer.sv
// Fork one input stream into NUM_LOADS independently drained FIFO branches.
module fanout_fork_buffer
  import fanout_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int NUM_LOADS = DEF_NUM_LOADS,
  parameter  int DEPTH     = DEF_DEPTH,
  localparam int CW        = cw_of(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LOADS-1:0]       ch_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LOADS-1:0]       out_valid,
  input  logic [NUM_LOADS-1:0]       out_ready,
  output logic [NUM_LOADS*WIDTH-1:0] out_data,
  output logic [NUM_LOADS*CW-1:0]    occupancy
);

  ch_status_t           status [NUM_LOADS];
  logic [NUM_LOADS-1:0] full_vec;
  logic [NUM_LOADS-1:0] wr_en;

  always_comb begin
    full_vec  = '0;
    out_valid = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      full_vec[i]  = status[i].full;
      out_valid[i] = ~status[i].empty;
    end
  end

  // Only registered full flags feed in_ready, so out_ready never reaches it combinationally.
  assign in_ready = ~|(ch_en & full_vec);
  assign wr_en    = ch_en & {NUM_LOADS{in_valid & in_ready}};

  for (genvar g = 0; g < NUM_LOADS; g++) begin : g_ch
    logic [MAX_CW-1:0] occ_unused;

    fanout_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (wr_en[g]),
      .pop_ready_i (out_ready[g]),
      .wr_data_i   (in_data),
      .rd_data_o   (out_data[g*WIDTH +: WIDTH]),
      .status_o    (status[g])
    );

    assign occ_unused            = status[g].occupancy;
    assign occupancy[g*CW +: CW] = status[g].occupancy[CW-1:0];
  end

endmodule
